uart_cmd_decoder: RTL and testbench

//   Sits directly downstream of the UART receiver. It consumes received bytes
//   (one-cycle data_ready strobes plus the end-of-packet pulse) and parses

---
 rtl/uart_cmd_decoder_if.sv | 24 ++
 rtl/uart_cmd_decoder.sv | 167 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and register-write output bundle for uart_cmd_decoder.
interface uart_cmd_decoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_endofpacket;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    output rx_data, rx_valid, rx_endofpacket,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_endofpacket,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from the UART byte stream and replays
// checksum-clean payloads as a gap-free burst of register writes.
module uart_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_LEN   = 16
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_decoder_if.slave bus
);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StLen   = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StChk   = 3'd4;
  localparam logic [2:0] StWrite = 3'd5;

  logic [2:0]        stateQ, stateD;
  logic [ADDR_W-1:0] baseQ, baseD;
  logic [LenW-1:0]   lenQ, lenD;
  logic [LenW-1:0]   idxQ, idxD;
  logic [7:0]        sumQ, sumD;
  logic [7:0]        payloadBuf [MAX_LEN];
  logic              bufWe;
  logic              wrEnQ, wrEnD;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrD;
  logic [7:0]        wrDataQ, wrDataD;
  logic              frameDoneQ, frameDoneD;
  logic              frameErrQ, frameErrD;
  logic              busyQ;
  logic [7:0]        chkSum;
  logic              lenOk;

  assign chkSum = sumQ + bus.rx_data;
  assign lenOk  = (bus.rx_data != 8'd0) && (32'(bus.rx_data) <= MAX_LEN);

  always_comb begin
    stateD     = stateQ;
    baseD      = baseQ;
    lenD       = lenQ;
    idxD       = idxQ;
    sumD       = sumQ;
    bufWe      = 1'b0;
    wrEnD      = 1'b0;
    wrAddrD    = wrAddrQ;
    wrDataD    = wrDataQ;
    frameDoneD = 1'b0;
    frameErrD  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) stateD = StAddr;
      end
      StAddr: begin
        if (bus.rx_valid) begin
          baseD  = bus.rx_data[ADDR_W-1:0];
          sumD   = bus.rx_data;
          stateD = StLen;
        end else if (bus.rx_endofpacket) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StLen: begin
        if (bus.rx_valid) begin
          if (lenOk) begin
            lenD   = LenW'(bus.rx_data);
            sumD   = sumQ + bus.rx_data;
            idxD   = '0;
            stateD = StData;
          end else begin
            frameErrD = 1'b1;
            stateD    = StIdle;
          end
        end else if (bus.rx_endofpacket) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StData: begin
        if (bus.rx_valid) begin
          bufWe = 1'b1;
          sumD  = sumQ + bus.rx_data;
          idxD  = idxQ + LenW'(1);
          if (idxQ + LenW'(1) == lenQ) stateD = StChk;
        end else if (bus.rx_endofpacket) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StChk: begin
        if (bus.rx_valid) begin
          if (chkSum == 8'd0) begin
            // Beat 0 leaves with the CHK byte so the burst starts one cycle later.
            stateD     = StWrite;
            wrEnD      = 1'b1;
            wrAddrD    = baseQ;
            wrDataD    = payloadBuf[0];
            idxD       = LenW'(1);
            frameDoneD = (lenQ == LenW'(1));
          end else begin
            frameErrD = 1'b1;
            stateD    = StIdle;
          end
        end else if (bus.rx_endofpacket) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StWrite: begin
        if (idxQ == lenQ) begin
          stateD = StIdle;
        end else begin
          wrEnD      = 1'b1;
          wrAddrD    = baseQ + ADDR_W'(idxQ);
          wrDataD    = payloadBuf[idxQ[IdxW-1:0]];
          idxD       = idxQ + LenW'(1);
          frameDoneD = (idxQ + LenW'(1) == lenQ);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      baseQ      <= '0;
      lenQ       <= '0;
      idxQ       <= '0;
      sumQ       <= '0;
      wrEnQ      <= 1'b0;
      wrAddrQ    <= '0;
      wrDataQ    <= '0;
      frameDoneQ <= 1'b0;
      frameErrQ  <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      baseQ      <= baseD;
      lenQ       <= lenD;
      idxQ       <= idxD;
      sumQ       <= sumD;
      wrEnQ      <= wrEnD;
      wrAddrQ    <= wrAddrD;
      wrDataQ    <= wrDataD;
      frameDoneQ <= frameDoneD;
      frameErrQ  <= frameErrD;
      busyQ      <= (stateD != StIdle);
    end
  end

  // Payload storage needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (bufWe) payloadBuf[idxQ[IdxW-1:0]] <= bus.rx_data;
  end

  assign bus.wr_en      = wrEnQ;
  assign bus.wr_addr    = wrAddrQ;
  assign bus.wr_data    = wrDataQ;
  assign bus.frame_done = frameDoneQ;
  assign bus.frame_err  = frameErrQ;
  assign bus.busy       = busyQ;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed and randomized frames against a frame-level model of the decoder.
module tb_uart_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_decoder_if #(.ADDR_W(8)) bus ();

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .ADDR_W(8), .MAX_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  wr_t wrQ[$];
  int  cyc = 0;
  int  errCnt = 0;
  int  badCnt = 0;
  int  passed = 0;
  int  failed = 0;
  int  total = 0;
  int  lastStrobe = 0;

  // Negedge monitor: logs every write beat with the cycle it was seen in.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en) wrQ.push_back('{cyc, bus.wr_addr, bus.wr_data, bus.frame_done});
    if (bus.frame_err) errCnt <= errCnt + 1;
    if ((bus.frame_err && bus.frame_done) || (bus.wr_en && !bus.busy)) badCnt <= badCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eop);
    @(posedge clk); #1;
    bus.rx_data        = b;
    bus.rx_valid       = 1'b1;
    bus.rx_endofpacket = eop;
    lastStrobe         = cyc;
    @(posedge clk); #1;
    bus.rx_valid       = 1'b0;
    bus.rx_endofpacket = 1'b0;
  endtask

  task automatic sendEop();
    @(posedge clk); #1;
    bus.rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    bus.rx_endofpacket = 1'b0;
  endtask

  function automatic logic [7:0] goodChk(input logic [7:0] base, input logic [7:0] len,
                                         input logic [7:0] pay[$]);
    int s = int'(base) + int'(len);
    foreach (pay[i]) s += int'(pay[i]);
    return 8'(256 - (s % 256));
  endfunction

  task automatic sendFrame(input logic [7:0] base, input logic [7:0] pay[$],
                           input logic [7:0] chk);
    sendByte(8'hA5, 1'b0);
    sendByte(base, 1'b0);
    sendByte(8'(pay.size()), 1'b0);
    foreach (pay[i]) sendByte(pay[i], 1'b0);
    sendByte(chk, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Expected burst: beat i writes pay[i] to base+i, one cycle after the CHK strobe plus i.
  task automatic checkBurst(input string tag, input logic [7:0] base, input logic [7:0] pay[$],
                            input int chkCyc);
    check({tag, ".count"}, 32'(wrQ.size()), 32'(pay.size()));
    foreach (pay[i]) begin
      if (i < wrQ.size()) begin
        check($sformatf("%s.beat%0d", tag, i), {wrQ[i].addr, wrQ[i].data},
              {8'(base + 8'(i)), pay[i]});
        check($sformatf("%s.done%0d", tag, i), 32'(wrQ[i].done), 32'(i == pay.size() - 1));
        check($sformatf("%s.cyc%0d", tag, i), 32'(wrQ[i].cyc), 32'(chkCyc + 1 + i));
      end
    end
  endtask

  initial begin
    logic [7:0] pay[$];
    logic [7:0] noPay[$];
    logic [7:0] base;
    logic [7:0] chk;
    int         e0;
    int         chkCyc;
    int         len;
    int         mode;

    bus.rx_data        = 8'h00;
    bus.rx_valid       = 1'b0;
    bus.rx_endofpacket = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.wr_en", 32'(bus.wr_en), 32'd0);
    check("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst.wr_data", 32'(bus.wr_data), 32'd0);
    check("rst.done", 32'(bus.frame_done), 32'd0);
    check("rst.err", 32'(bus.frame_err), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Good frame with three payload bytes
    pay = '{8'h11, 8'h22, 8'h33};
    wrQ.delete(); e0 = errCnt;
    sendFrame(8'h10, pay, goodChk(8'h10, 8'h03, pay));
    chkCyc = lastStrobe;
    waitIdle("t1");
    checkBurst("t1", 8'h10, pay, chkCyc);
    check("t1.err", 32'(errCnt - e0), 32'd0);

    // Same frame, corrupted checksum
    wrQ.delete(); e0 = errCnt;
    sendFrame(8'h10, pay, goodChk(8'h10, 8'h03, pay) + 8'h01);
    waitIdle("t2");
    check("t2.err", 32'(errCnt - e0), 32'd1);
    check("t2.writes", 32'(wrQ.size()), 32'd0);
    check("t2.busy", 32'(bus.busy), 32'd0);

    // Out-of-range lengths, each rejected right after the LEN byte
    wrQ.delete();
    sendByte(8'hA5, 1'b0); sendByte(8'h10, 1'b0); sendByte(8'h00, 1'b0);
    @(negedge clk);
    check("t3.len0.err", 32'(bus.frame_err), 32'd1);
    check("t3.len0.busy", 32'(bus.busy), 32'd0);
    sendByte(8'hA5, 1'b0); sendByte(8'h10, 1'b0); sendByte(8'h11, 1'b0);
    @(negedge clk);
    check("t3.len17.err", 32'(bus.frame_err), 32'd1);
    check("t3.len17.busy", 32'(bus.busy), 32'd0);
    sendFrame(8'h10, pay, goodChk(8'h10, 8'h03, pay));
    chkCyc = lastStrobe;
    waitIdle("t3");
    checkBurst("t3", 8'h10, pay, chkCyc);

    // Leading garbage, then a frame whose addresses wrap past 0xFF
    wrQ.delete(); e0 = errCnt;
    sendByte(8'h00, 1'b0); sendByte(8'hFF, 1'b0); sendByte(8'h5A, 1'b0);
    pay = '{8'hAA, 8'hBB};
    sendFrame(8'hFF, pay, goodChk(8'hFF, 8'h02, pay));
    chkCyc = lastStrobe;
    waitIdle("t4");
    checkBurst("t4", 8'hFF, pay, chkCyc);
    check("t4.err", 32'(errCnt - e0), 32'd0);

    // End-of-packet mid-payload aborts
    wrQ.delete(); e0 = errCnt;
    sendByte(8'hA5, 1'b0); sendByte(8'h20, 1'b0); sendByte(8'h04, 1'b0);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendEop();
    @(negedge clk);
    check("t5.eop.err", 32'(bus.frame_err), 32'd1);
    waitIdle("t5a");
    check("t5.eop.writes", 32'(wrQ.size()), 32'd0);
    check("t5.eop.errcnt", 32'(errCnt - e0), 32'd1);

    // Reset during the second write beat
    wrQ.delete();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    sendFrame(8'h20, pay, goodChk(8'h20, 8'h04, pay));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5.rst.beat1", {31'd0, bus.wr_en} | (32'(bus.wr_addr) << 8), 32'h2101);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5.rst.wr_en", 32'(bus.wr_en), 32'd0);
    check("t5.rst.outs", {bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_err, bus.busy},
          32'd0);
    repeat (6) @(negedge clk);
    check("t5.rst.writes", 32'(wrQ.size()), 32'd2);

    // Byte with coincident end-of-packet is kept; bytes during the burst are dropped
    wrQ.delete(); e0 = errCnt;
    pay = '{8'h44, 8'h55, 8'h66};
    sendByte(8'hA5, 1'b0); sendByte(8'h30, 1'b0); sendByte(8'h03, 1'b0);
    sendByte(8'h44, 1'b1); sendByte(8'h55, 1'b0); sendByte(8'h66, 1'b0);
    sendByte(goodChk(8'h30, 8'h03, pay), 1'b0);
    chkCyc = lastStrobe;
    sendByte(8'hA5, 1'b0);
    waitIdle("t6");
    checkBurst("t6", 8'h30, pay, chkCyc);
    check("t6.err", 32'(errCnt - e0), 32'd0);
    check("t6.sync_dropped", 32'(bus.busy), 32'd0);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      wrQ.delete(); e0 = errCnt;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        sendByte(junk, 1'b0);
      end
      base = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        sendByte(8'hA5, 1'b0); sendByte(base, 1'b0); sendByte(8'(len), 1'b0);
        waitIdle($sformatf("r%0d", f));
        checkBurst($sformatf("r%0d.badlen", f), base, noPay, 0);
        check($sformatf("r%0d.badlen.err", f), 32'(errCnt - e0), 32'd1);
      end else begin
        pay.delete();
        len = $urandom_range(1, 16);
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
        chk = goodChk(base, 8'(len), pay);
        if (mode <= 2) chk = chk + 8'($urandom_range(1, 255));
        sendFrame(base, pay, chk);
        chkCyc = lastStrobe;
        waitIdle($sformatf("r%0d", f));
        if (mode <= 2) begin
          checkBurst($sformatf("r%0d.badchk", f), base, noPay, chkCyc);
          check($sformatf("r%0d.badchk.err", f), 32'(errCnt - e0), 32'd1);
        end else begin
          checkBurst($sformatf("r%0d.good", f), base, pay, chkCyc);
          check($sformatf("r%0d.good.err", f), 32'(errCnt - e0), 32'd0);
        end
      end
    end

    check("never.err_done_or_stray_wr", 32'(badCnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
